// File: rtl/ltc2308_scan_sched_pkg.sv
// Shared LTC2308 definitions: conf word bit layout, scheduler state encoding and helpers.
// Pure declarations; no timing or flow control of its own.
package ltc2308_scan_sched_pkg;

    localparam int NUM_CH = 8;
    localparam int CH_W   = 3;
    localparam int CONF_W = 6;

    // LTC2308 DIN word: S/D, O/S, S1, S0, UNI, SLP
    localparam int CONF_SD  = 5;
    localparam int CONF_OS  = 4;
    localparam int CONF_S1  = 3;
    localparam int CONF_S0  = 2;
    localparam int CONF_UNI = 1;
    localparam int CONF_SLP = 0;

    localparam logic [CH_W:0] CH_NONE = (CH_W+1)'(NUM_CH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_LOW,
        ST_WAIT_HIGH,
        ST_STORE
    } state_e;

    typedef enum logic {
        SRC_SCAN = 1'b0,
        SRC_HOST = 1'b1
    } src_e;

    function automatic logic [CONF_W-1:0] conf_word(input logic [CH_W-1:0] ch, input logic uni);
        logic [CONF_W-1:0] w;
        w           = '0;
        w[CONF_SD]  = 1'b1;
        w[CONF_OS]  = ch[0];
        w[CONF_S1]  = ch[2];
        w[CONF_S0]  = ch[1];
        w[CONF_UNI] = uni;
        w[CONF_SLP] = 1'b0;
        return w;
    endfunction

    // Lowest set mask bit at or above ptr; CH_NONE when there is none.
    function automatic logic [CH_W:0] next_ch(input logic [NUM_CH-1:0] mask, input logic [CH_W:0] ptr);
        logic [CH_W:0] r;
        r = CH_NONE;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i] && (i >= int'(ptr))) begin
                r = i[CH_W:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ltc2308_scan_sched_if.sv
// Host request/response and LTC2308 driver handshake bundle.
// master = scheduler side, slave = host plus SPI driver side.
interface ltc2308_scan_sched_if #(
    parameter int W = 12
);
    import ltc2308_scan_sched_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [CH_W-1:0]   req_ch;
    logic              rsp_valid;
    logic              rsp_err;
    logic [W-1:0]      rsp_data;
    logic [CONF_W-1:0] adc_conf;
    logic              adc_start;
    logic              adc_ready;
    logic [W-1:0]      adc_res;

    modport master (
        input  req_valid, req_ch, adc_ready, adc_res,
        output req_ready, rsp_valid, rsp_err, rsp_data, adc_conf, adc_start
    );

    modport slave (
        output req_valid, req_ch, adc_ready, adc_res,
        input  req_ready, rsp_valid, rsp_err, rsp_data, adc_conf, adc_start
    );

endinterface

// File: rtl/ltc2308_scan_sched_period_timer.sv
// Sweep period timer: one-cycle tick every `period` enabled cycles (every cycle when 0).
// Counter freezes while disabled and reloads to zero on each tick.
module ltc2308_period_timer #(
    parameter int RATE_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [RATE_W-1:0] period,
    output logic              tick
);

    logic [RATE_W-1:0] cnt_q, cnt_d;
    logic              hit;

    assign hit = (period == '0) || (cnt_q >= (period - 1'b1));

    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (en) begin
            if (hit) begin
                tick  = 1'b1;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ltc2308_scan_sched.sv
// Shares one LTC2308 driver between a periodic masked channel sweep and a host port (host wins).
// One conversion in flight; host is held off via req_ready outside IDLE; results land in a register file.
module ltc2308_scan_sched
    import ltc2308_scan_sched_pkg::*;
#(
    parameter int NCH     = 8,
    parameter int W       = 12,
    parameter int RATE_W  = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 scan_en,
    input  logic [NCH-1:0]       ch_mask,
    input  logic                 uni,
    input  logic [RATE_W-1:0]    period,
    input  logic [CH_W-1:0]      rd_addr,
    output logic [W-1:0]         rd_data,
    output logic                 sample_valid,
    output logic [CH_W-1:0]      sample_ch,
    output logic                 overrun,
    output logic                 timeout_err,
    ltc2308_scan_sched_if.master bus
);

    localparam int            TMO_W   = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT);

    state_e            state_q, state_d;
    src_e              src_q, src_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [CH_W:0]     ptr_q, ptr_d;
    logic              sweep_q, sweep_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [CONF_W-1:0] conf_q, conf_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [W-1:0]      rsp_data_q, rsp_data_d;
    logic              sample_valid_q, sample_valid_d;
    logic [CH_W-1:0]   sample_ch_q, sample_ch_d;
    logic              overrun_q, overrun_d;
    logic              timeout_err_q, timeout_err_d;
    logic [W-1:0]      result_q [NCH];
    logic [W-1:0]      rd_data_q;
    logic              wr_en;
    logic              done, abort;
    logic              tick;
    logic [CH_W:0]     scan_pick, after_pick;

    ltc2308_period_timer #(.RATE_W(RATE_W)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .en     (scan_en),
        .period (period),
        .tick   (tick)
    );

    assign scan_pick  = next_ch(ch_mask, ptr_q);
    assign after_pick = next_ch(ch_mask, {1'b0, ch_q} + 1'b1);

    always_comb begin
        state_d        = state_q;
        src_d          = src_q;
        ch_d           = ch_q;
        ptr_d          = ptr_q;
        sweep_d        = sweep_q;
        tmo_d          = tmo_q;
        conf_d         = conf_q;
        rsp_valid_d    = 1'b0;
        rsp_err_d      = 1'b0;
        rsp_data_d     = rsp_data_q;
        sample_valid_d = 1'b0;
        sample_ch_d    = sample_ch_q;
        overrun_d      = overrun_q;
        timeout_err_d  = timeout_err_q;
        wr_en          = 1'b0;
        done           = 1'b0;
        abort          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    src_d   = SRC_HOST;
                    ch_d    = bus.req_ch;
                    conf_d  = conf_word(bus.req_ch, uni);
                    state_d = ST_ISSUE;
                end else if (sweep_q) begin
                    if (!scan_en || (scan_pick == CH_NONE)) begin
                        sweep_d = 1'b0;
                    end else begin
                        src_d   = SRC_SCAN;
                        ch_d    = scan_pick[CH_W-1:0];
                        conf_d  = conf_word(scan_pick[CH_W-1:0], uni);
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                tmo_d   = '0;
                state_d = ST_WAIT_LOW;
            end
            ST_WAIT_LOW, ST_WAIT_HIGH: begin
                if (tmo_q == TMO_MAX) begin
                    abort         = 1'b1;
                    timeout_err_d = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                    if ((state_q == ST_WAIT_LOW) && !bus.adc_ready) begin
                        state_d = ST_WAIT_HIGH;
                    end else if ((state_q == ST_WAIT_HIGH) && bus.adc_ready) begin
                        state_d = ST_STORE;
                    end
                end
            end
            ST_STORE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A timed-out scan channel is skipped exactly like a stored one, minus the write.
        if (done || abort) begin
            if (src_q == SRC_HOST) begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = abort;
                rsp_data_d  = abort ? '0 : bus.adc_res;
            end else begin
                wr_en          = done;
                sample_valid_d = done;
                if (done) begin
                    sample_ch_d = ch_q;
                end
                ptr_d = {1'b0, ch_q} + 1'b1;
                if (after_pick == CH_NONE) begin
                    sweep_d = 1'b0;
                end
            end
        end

        // Back-to-back mode (period 0) ticks every cycle, so only a real period can overrun.
        if (tick) begin
            if (sweep_q) begin
                if (period != '0) begin
                    overrun_d = 1'b1;
                end
            end else begin
                sweep_d = 1'b1;
                ptr_d   = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            src_q          <= SRC_SCAN;
            ch_q           <= '0;
            ptr_q          <= '0;
            sweep_q        <= 1'b0;
            tmo_q          <= '0;
            conf_q         <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_err_q      <= 1'b0;
            rsp_data_q     <= '0;
            sample_valid_q <= 1'b0;
            sample_ch_q    <= '0;
            overrun_q      <= 1'b0;
            timeout_err_q  <= 1'b0;
            rd_data_q      <= '0;
            for (int i = 0; i < NCH; i++) begin
                result_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            src_q          <= src_d;
            ch_q           <= ch_d;
            ptr_q          <= ptr_d;
            sweep_q        <= sweep_d;
            tmo_q          <= tmo_d;
            conf_q         <= conf_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_err_q      <= rsp_err_d;
            rsp_data_q     <= rsp_data_d;
            sample_valid_q <= sample_valid_d;
            sample_ch_q    <= sample_ch_d;
            overrun_q      <= overrun_d;
            timeout_err_q  <= timeout_err_d;
            rd_data_q      <= result_q[rd_addr];
            if (wr_en) begin
                result_q[ch_q] <= bus.adc_res;
            end
        end
    end

    assign bus.req_ready = (state_q == ST_IDLE) && !rst;
    assign bus.adc_start = (state_q == ST_ISSUE);
    assign bus.adc_conf  = conf_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_data  = rsp_data_q;
    assign rd_data       = rd_data_q;
    assign sample_valid  = sample_valid_q;
    assign sample_ch     = sample_ch_q;
    assign overrun       = overrun_q;
    assign timeout_err   = timeout_err_q;

endmodule
